// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared types and default parameter values for the PE
// convolution controller (pe_ctrl_fsm) and its flag delay line.
//   pe_state_t   : controller state encoding
//   *_DEF        : default values for TILE_LEN, KSIZE, CH_GRAN, PIPE_DLY
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FINISH = 2'd3
  } pe_state_t;

  localparam int TILE_LEN_DEF = 16;
  localparam int KSIZE_DEF    = 3;
  localparam int CH_GRAN_DEF  = 8;
  localparam int PIPE_DLY_DEF = 4;

endpackage

// File: rtl/pe_ctrl_fsm_delay_line.sv
// pe_delay_line: fixed-depth shift register that delays the PE flags so they
// line up with the datapath output. Resets every stage to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : WIDTH-bit input sampled every cycle
//   dout       : din delayed exactly DEPTH cycles
module pe_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pe_ctrl_fsm.sv
// pe_ctrl_fsm: sequences a processing-element convolution job. A job is
// armed by start_conv (config latched), each tile is launched by start_again.
// A tile runs ci channel passes of KSIZE preload + TILE_LEN stream cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : (PE_CTRL_STALL_EN only) freeze FSM, gate reads
//   start_conv          : latch cfg_ci/cfg_tiles and arm job (IDLE only)
//   start_again         : launch next tile of an armed job (IDLE only)
//   cfg_ci              : channel groups minus 1 (ci = (cfg_ci+1)*CH_GRAN)
//   cfg_tiles           : tiles per job minus 1
//   ifm_read, wgt_read  : input-feature / weight fetch enables
//   p_valid_output      : partial-sum valid, delayed PIPE_DLY cycles
//   last_chanel_output  : last-channel pass flag, delayed PIPE_DLY cycles
//   end_conv            : one-cycle job-complete pulse
//   busy                : high whenever the FSM is outside IDLE
// Optional feature macro: PE_CTRL_STALL_EN (adds the stall input).
//
// state     | meaning
// ST_IDLE   | waiting for start_conv / start_again
// ST_LOAD   | KSIZE-cycle weight + ifm preload for one channel pass
// ST_STREAM | TILE_LEN-cycle ifm streaming, partial sums valid
// ST_FINISH | one-cycle end_conv pulse, job then disarmed
module pe_ctrl_fsm
  import pe_ctrl_pkg::*;
#(
  parameter int TILE_LEN = TILE_LEN_DEF,
  parameter int KSIZE    = KSIZE_DEF,
  parameter int CH_GRAN  = CH_GRAN_DEF,
  parameter int CFG_W    = 2,
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PE_CTRL_STALL_EN
  input  logic             stall,
`endif
  input  logic             start_conv,
  input  logic             start_again,
  input  logic [CFG_W-1:0] cfg_ci,
  input  logic [CFG_W+3:0] cfg_tiles,
  output logic             ifm_read,
  output logic             wgt_read,
  output logic             p_valid_output,
  output logic             last_chanel_output,
  output logic             end_conv,
  output logic             busy
);

  // Wide enough for (2**CFG_W)*CH_GRAN and (2**(CFG_W+4)) without wrap.
  localparam int CI_W   = CFG_W + $clog2(CH_GRAN) + 1;
  localparam int NT_W   = CFG_W + 5;
  localparam int PH_MAX = (TILE_LEN > KSIZE) ? TILE_LEN : KSIZE;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  pe_state_t       state;
  logic [PH_W-1:0] ph_cnt;
  logic [CI_W-1:0] chan;
  logic [CI_W-1:0] ci_m1;
  logic [NT_W-1:0] ntile;
  logic [NT_W-1:0] tcnt;
  logic            armed;
  logic            ifm_q;
  logic            wgt_q;
  logic            stall_i;
  logic            p_valid;
  logic            last_chanel;
  logic [CI_W-1:0] ci_calc;
  logic [1:0]      flags_dly;

`ifdef PE_CTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign ci_calc = (CI_W'(cfg_ci) + CI_W'(1)) * CI_W'(CH_GRAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ph_cnt   <= '0;
      chan     <= '0;
      ci_m1    <= '0;
      ntile    <= '0;
      tcnt     <= '0;
      armed    <= 1'b0;
      ifm_q    <= 1'b0;
      wgt_q    <= 1'b0;
      end_conv <= 1'b0;
      busy     <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        ST_IDLE: begin
          if (start_conv) begin
            ci_m1 <= ci_calc - CI_W'(1);
            ntile <= NT_W'(cfg_tiles) + NT_W'(1);
            armed <= 1'b1;
            tcnt  <= '0;
            chan  <= '0;
          end
          // start_conv in the same cycle arms the job and this tile uses the new config
          if (start_again && (armed || start_conv)) begin
            state  <= ST_LOAD;
            ph_cnt <= PH_W'(KSIZE - 1);
            ifm_q  <= 1'b1;
            wgt_q  <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ph_cnt == '0) begin
            state  <= ST_STREAM;
            ph_cnt <= PH_W'(TILE_LEN - 1);
            wgt_q  <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        ST_STREAM: begin
          if (ph_cnt == '0) begin
            if (chan != ci_m1) begin
              chan   <= chan + CI_W'(1);
              state  <= ST_LOAD;
              ph_cnt <= PH_W'(KSIZE - 1);
              wgt_q  <= 1'b1;
            end else begin
              chan  <= '0;
              ifm_q <= 1'b0;
              tcnt  <= tcnt + NT_W'(1);
              if ((tcnt + NT_W'(1)) == ntile) begin
                state    <= ST_FINISH;
                end_conv <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        ST_FINISH: begin
          state    <= ST_IDLE;
          end_conv <= 1'b0;
          busy     <= 1'b0;
          armed    <= 1'b0;
          tcnt     <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall gates the fetch enables in the very cycle it is asserted.
  assign ifm_read    = ifm_q & ~stall_i;
  assign wgt_read    = wgt_q & ~stall_i;
  assign p_valid     = (state == ST_STREAM) & ~stall_i;
  assign last_chanel = (state == ST_STREAM) && (chan == ci_m1);

  pe_delay_line #(
    .DEPTH (PIPE_DLY),
    .WIDTH (2)
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({p_valid, last_chanel}),
    .dout  (flags_dly)
  );

  assign p_valid_output     = flags_dly[1];
  assign last_chanel_output = flags_dly[0];

endmodule

// File: tb/tb_pe_ctrl_fsm.sv
module tb_pe_ctrl_fsm;
  localparam int TILE_LEN = 16;
  localparam int KSIZE    = 3;
  localparam int CH_GRAN  = 8;
  localparam int CFG_W    = 2;
  localparam int PIPE_DLY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_conv = 1'b0;
  logic start_again = 1'b0;
  logic stall = 1'b0;
  logic [CFG_W-1:0] cfg_ci = '0;
  logic [CFG_W+3:0] cfg_tiles = '0;
  logic ifm_read, wgt_read, p_valid_output, last_chanel_output, end_conv, busy;

  always #5 clk = ~clk;

  pe_ctrl_fsm #(
    .TILE_LEN (TILE_LEN), .KSIZE (KSIZE), .CH_GRAN (CH_GRAN),
    .CFG_W (CFG_W), .PIPE_DLY (PIPE_DLY)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
`ifdef PE_CTRL_STALL_EN
    .stall              (stall),
`endif
    .start_conv         (start_conv),
    .start_again        (start_again),
    .cfg_ci             (cfg_ci),
    .cfg_tiles          (cfg_tiles),
    .ifm_read           (ifm_read),
    .wgt_read           (wgt_read),
    .p_valid_output     (p_valid_output),
    .last_chanel_output (last_chanel_output),
    .end_conv           (end_conv),
    .busy               (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: per-cycle expectation schedule
  typedef struct packed {
    logic ifm, wgt, pv, lc, endc, bsy;
  } exp_t;

  exp_t sched[$];
  exp_t cur = '0;
  int   m_ci = 0, m_ntile = 0, m_tcnt = 0;
  bit   m_armed = 1'b0;
  logic pv_hist [1:PIPE_DLY];
  logic lc_hist [1:PIPE_DLY];

  function automatic exp_t mk(logic a, logic b, logic c, logic d, logic e, logic f);
    exp_t r;
    r.ifm = a; r.wgt = b; r.pv = c; r.lc = d; r.endc = e; r.bsy = f;
    return r;
  endfunction

  // One tile = ci passes of (KSIZE preload, TILE_LEN stream), plus an
  // end_conv cycle if this tile finishes the job.
  function automatic void build_tile();
    for (int c = 0; c < m_ci; c++) begin
      for (int k = 0; k < KSIZE; k++) sched.push_back(mk(1, 1, 0, 0, 0, 1));
      for (int t = 0; t < TILE_LEN; t++) sched.push_back(mk(1, 0, 1, (c == m_ci - 1), 0, 1));
    end
    m_tcnt++;
    if (m_tcnt == m_ntile) begin
      sched.push_back(mk(0, 0, 0, 0, 1, 1));
      m_armed = 1'b0;
      m_tcnt  = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
      cur = '0;
      m_armed = 1'b0; m_tcnt = 0; m_ci = 0; m_ntile = 0;
      for (int i = 1; i <= PIPE_DLY; i++) begin pv_hist[i] = 1'b0; lc_hist[i] = 1'b0; end
    end else begin
      for (int i = PIPE_DLY; i > 1; i--) begin pv_hist[i] = pv_hist[i-1]; lc_hist[i] = lc_hist[i-1]; end
      pv_hist[1] = cur.pv & ~stall;
      lc_hist[1] = cur.lc;
      if (!stall) begin
        if (!cur.bsy) begin
          if (start_conv) begin
            m_ci    = (int'(cfg_ci) + 1) * CH_GRAN;
            m_ntile = int'(cfg_tiles) + 1;
            m_armed = 1'b1;
            m_tcnt  = 0;
          end
          if (start_again && m_armed) build_tile();
        end
        cur = (sched.size() > 0) ? sched.pop_front() : exp_t'(0);
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    check1("ifm_read", ifm_read, cur.ifm & ~stall);
    check1("wgt_read", wgt_read, cur.wgt & ~stall);
    check1("end_conv", end_conv, cur.endc);
    check1("busy", busy, cur.bsy);
    check1("p_valid_output", p_valid_output, pv_hist[PIPE_DLY]);
    check1("last_chanel_output", last_chanel_output, lc_hist[PIPE_DLY]);
  end

  // ---------------- activity counters used by literal checks
  bit cnt_en = 1'b0;
  int n_busy, n_ifm, n_wgt, n_pv, n_lc, n_endc, n_burst;
  logic pv_prev = 1'b0;

  always @(negedge clk) begin
    if (cnt_en) begin
      n_busy += int'(busy);
      n_ifm  += int'(ifm_read);
      n_wgt  += int'(wgt_read);
      n_pv   += int'(p_valid_output);
      n_lc   += int'(last_chanel_output);
      n_endc += int'(end_conv);
      if (p_valid_output && !pv_prev) n_burst++;
    end
    pv_prev = p_valid_output;
  end

  task automatic clear_cnt();
    n_busy = 0; n_ifm = 0; n_wgt = 0; n_pv = 0; n_lc = 0; n_endc = 0; n_burst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit sc, input bit sa, input int ci, input int tiles);
    start_conv  = sc;
    start_again = sa;
    cfg_ci      = CFG_W'(ci);
    cfg_tiles   = (CFG_W+4)'(tiles);
    tick();
    start_conv  = 1'b0;
    start_again = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    tick();
    while (busy && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cnt();
    repeat (3) tick();
    check1("reset ifm_read", ifm_read, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset p_valid_output", p_valid_output, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Default single tile: ci=8, 8*(3+16)=152 fetch cycles + 1 FINISH cycle.
    clear_cnt(); cnt_en = 1'b1;
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    wait_idle(400, "basic idle");
    repeat (PIPE_DLY + 2) tick();
    cnt_en = 1'b0;
    check_int("basic ifm cycles", n_ifm, 152);
    check_int("basic wgt cycles", n_wgt, 24);
    check_int("basic busy cycles", n_busy, 153);
    check_int("basic pv_out cycles", n_pv, 128);
    check_int("basic pv_out bursts", n_burst, 8);
    check_int("basic lc_out cycles", n_lc, 16);
    check_int("basic end_conv cycles", n_endc, 1);

    // Three tiles, config latched together with start_again, busy pulses ignored.
    clear_cnt(); cnt_en = 1'b1;
    pulse(1, 1, 1, 2);
    repeat (5) tick();
    pulse(1, 1, 3, 0);
    wait_idle(400, "tile0 idle");
    check_int("tile0 end_conv", n_endc, 0);
    check_int("tile0 ifm cycles", n_ifm, 304);
    repeat (4) tick();
    pulse(0, 1, 3, 0);
    repeat (50) tick();
    pulse(0, 1, 3, 0);
    wait_idle(400, "tile1 idle");
    check_int("tile1 end_conv", n_endc, 0);
    repeat (4) tick();
    pulse(0, 1, 0, 0);
    wait_idle(400, "tile2 idle");
    repeat (PIPE_DLY + 2) tick();
    cnt_en = 1'b0;
    check_int("job end_conv", n_endc, 1);
    check_int("job ifm cycles", n_ifm, 912);

    // Reset mid-tile with ci=32, then start_again alone must not launch.
    pulse(1, 0, 3, 0);
    pulse(0, 1, 3, 0);
    repeat (98) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check1("rst ifm_read", ifm_read, 1'b0);
    check1("rst wgt_read", wgt_read, 1'b0);
    check1("rst p_valid_output", p_valid_output, 1'b0);
    check1("rst last_chanel_output", last_chanel_output, 1'b0);
    check1("rst busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse(0, 1, 3, 0);
    repeat (20) tick();
    check1("post-reset start_again busy", busy, 1'b0);

`ifdef PE_CTRL_STALL_EN
    pulse(1, 0, 0, 0);
    clear_cnt(); cnt_en = 1'b1;
    pulse(0, 1, 0, 0);
    repeat (30) tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    wait_idle(400, "stall idle");
    repeat (PIPE_DLY + 2) tick();
    cnt_en = 1'b0;
    check_int("stall ifm cycles", n_ifm, 152);
    check_int("stall busy cycles", n_busy, 158);
    check_int("stall pv_out cycles", n_pv, 128);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      start_conv  = ($urandom_range(0, 31) == 0);
      start_again = ($urandom_range(0, 7) == 0);
      cfg_ci      = CFG_W'($urandom_range(0, 1));
      cfg_tiles   = (CFG_W+4)'($urandom_range(0, 2));
`ifdef PE_CTRL_STALL_EN
      stall       = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    start_conv = 1'b0; start_again = 1'b0; stall = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
